// File: rtl/fifo_burst_reader.sv
// Drain-side controller for the 16-entry byte FIFO: pops fixed-length bursts at threshold,
// or flushes a partial packet on idle timeout / explicit request, onto a registered valid/ready stream.
module fifo_burst_reader #(
   parameter int DATA_W    = 8,
   parameter int BURST_LEN = 8,
   parameter int TIMEOUT   = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              flush_req,
   input  logic              fifo_empty,
   input  logic              fifo_threshold,
   input  logic [DATA_W-1:0] fifo_data,
   output logic              fifo_rd,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   output logic              m_last,
   output logic              busy,
   output logic [15:0]       burst_count,
   output logic [15:0]       byte_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_BURST,
      S_FLUSH,
      S_FLUSH_EVAL,
      S_FLUSH_OUT
   } state_t;

   localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);
   localparam logic [3:0]  POP_LAST   = 4'(BURST_LEN - 1);
   localparam logic [3:0]  POP_MAX    = 4'(BURST_LEN);

   state_t            r_state, w_state_next;
   logic [15:0]       r_timer, w_timer_next;
   logic [3:0]        r_pop_cnt, w_pop_cnt_next;
   logic [DATA_W-1:0] r_hold, w_hold_next;
   logic [DATA_W-1:0] r_m_data, w_m_data_next;
   logic              r_m_valid, w_m_valid_next;
   logic              r_m_last, w_m_last_next;
   logic              r_busy;
   logic [15:0]       r_burst_count, r_byte_count;
   logic              w_accept, w_slot_free, w_fifo_rd, w_burst_done;

   assign w_accept    = r_m_valid & m_ready;
   assign w_slot_free = ~r_m_valid | w_accept;

   always_comb begin
      w_state_next   = r_state;
      w_timer_next   = '0;
      w_pop_cnt_next = r_pop_cnt;
      w_hold_next    = r_hold;
      w_m_data_next  = r_m_data;
      w_m_valid_next = r_m_valid;
      w_m_last_next  = r_m_last;
      w_fifo_rd      = 1'b0;
      w_burst_done   = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (enable && fifo_threshold) begin
               w_state_next   = S_BURST;
               w_pop_cnt_next = '0;
            end else if (enable && !fifo_empty && (flush_req || r_timer == TIMER_LAST)) begin
               w_state_next   = S_FLUSH;
               w_pop_cnt_next = '0;
            end else if (enable && !fifo_empty) begin
               w_timer_next = r_timer + 16'd1;
            end
         end
         S_BURST: begin
            if (w_accept) begin
               w_m_valid_next = 1'b0;
               if (r_m_last) begin
                  w_m_last_next = 1'b0;
                  w_burst_done  = 1'b1;
                  w_state_next  = S_IDLE;
               end
            end
            // A pop refills the slot in the same cycle the previous byte leaves it
            if (w_slot_free && !fifo_empty && r_pop_cnt < POP_MAX) begin
               w_fifo_rd      = 1'b1;
               w_m_data_next  = fifo_data;
               w_m_valid_next = 1'b1;
               w_m_last_next  = (r_pop_cnt == POP_LAST);
               w_pop_cnt_next = r_pop_cnt + 4'd1;
            end
         end
         S_FLUSH: begin
            if (w_slot_free && !fifo_empty) begin
               w_fifo_rd    = 1'b1;
               w_hold_next  = fifo_data;
               w_state_next = S_FLUSH_EVAL;
            end
         end
         S_FLUSH_EVAL: begin
            // fifo_empty now reflects the pop made in the previous cycle
            w_m_data_next  = r_hold;
            w_m_valid_next = 1'b1;
            w_m_last_next  = fifo_empty || (r_pop_cnt == POP_LAST);
            w_pop_cnt_next = r_pop_cnt + 4'd1;
            w_state_next   = S_FLUSH_OUT;
         end
         S_FLUSH_OUT: begin
            if (w_accept) begin
               w_m_valid_next = 1'b0;
               if (r_m_last) begin
                  w_m_last_next = 1'b0;
                  w_burst_done  = 1'b1;
                  w_state_next  = S_IDLE;
               end else begin
                  w_state_next = S_FLUSH;
               end
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_timer       <= '0;
         r_pop_cnt     <= '0;
         r_hold        <= '0;
         r_m_data      <= '0;
         r_m_valid     <= 1'b0;
         r_m_last      <= 1'b0;
         r_busy        <= 1'b0;
         r_burst_count <= '0;
         r_byte_count  <= '0;
      end else begin
         r_state   <= w_state_next;
         r_timer   <= w_timer_next;
         r_pop_cnt <= w_pop_cnt_next;
         r_hold    <= w_hold_next;
         r_m_data  <= w_m_data_next;
         r_m_valid <= w_m_valid_next;
         r_m_last  <= w_m_last_next;
         r_busy    <= (w_state_next != S_IDLE);
         if (w_burst_done) r_burst_count <= r_burst_count + 16'd1;
         if (w_accept)     r_byte_count  <= r_byte_count + 16'd1;
      end
   end

   assign fifo_rd     = w_fifo_rd;
   assign m_valid     = r_m_valid;
   assign m_data      = r_m_data;
   assign m_last      = r_m_last;
   assign busy        = r_busy;
   assign burst_count = r_burst_count;
   assign byte_count  = r_byte_count;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Self-checking bench for fifo_burst_reader: bench-side FIFO, packet-level scoreboard,
// directed latency/timeout/reset cases and randomized batches.
module tb_fifo_burst_reader;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       enable = 1'b0;
   logic       flush_req = 1'b0;
   logic       fifo_empty;
   logic       fifo_threshold;
   logic [7:0] fifo_data;
   logic       fifo_rd;
   logic       m_valid;
   logic       m_ready = 1'b0;
   logic [7:0] m_data;
   logic       m_last;
   logic       busy;
   logic [15:0] burst_count;
   logic [15:0] byte_count;

   always #5 clk = ~clk;

   fifo_burst_reader #(.DATA_W(8), .BURST_LEN(8), .TIMEOUT(32)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .flush_req(flush_req),
      .fifo_empty(fifo_empty), .fifo_threshold(fifo_threshold), .fifo_data(fifo_data),
      .fifo_rd(fifo_rd), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .m_last(m_last), .busy(busy), .burst_count(burst_count), .byte_count(byte_count)
   );

   // Bench-side 16-entry FIFO: writes from the stimulus process, pops on fifo_rd
   logic [7:0]  fmem [16];
   int unsigned wr_total = 0;
   int unsigned rd_total = 0;
   assign fifo_empty     = (wr_total == rd_total);
   assign fifo_threshold = ((wr_total - rd_total) >= 8);
   assign fifo_data      = fmem[rd_total[3:0]];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd_total <= wr_total;
      else if (fifo_rd && !fifo_empty) rd_total <= rd_total + 1;
   end

   // Scoreboard: expected bytes with their last flags, plus expected counters
   logic [7:0] exp_d [$];
   bit         exp_l [$];
   int exp_bytes = 0, exp_bursts = 0;
   int n_vec = 0, n_err = 0;
   int cyc_n = 0;
   int first_rd, last_rd, n_rd, first_val, n_val, last_acc, n_acc;
   bit prev_stall = 0;
   logic [7:0] prev_data;
   logic prev_last;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc_n);
      end
   endtask

   task automatic fifo_write(input logic [7:0] d);
      fmem[wr_total[3:0]] = d;
      wr_total = wr_total + 1;
   endtask

   // n bytes into an empty FIFO drain as full bursts of 8 followed by one partial flush
   task automatic push_batch(input int n, input logic [7:0] base, input bit rnd);
      logic [7:0] d;
      for (int i = 0; i < n; i++) begin
         d = rnd ? 8'($urandom) : base + 8'(i);
         fifo_write(d);
         exp_d.push_back(d);
         exp_l.push_back(((i % 8) == 7) || (i == n - 1));
      end
      exp_bytes  += n;
      exp_bursts += (n + 7) / 8;
      $display("batch: %0d bytes written, expect %0d packets", n, (n + 7) / 8);
   endtask

   task automatic arm();
      first_rd = -1; last_rd = -1; n_rd = 0;
      first_val = -1; n_val = 0; last_acc = -1; n_acc = 0;
   endtask

   // One cycle: inputs already applied, sample just after settling, then advance
   task automatic cyc();
      logic [7:0] d;
      bit l;
      #1;
      check("rd_while_empty", {31'd0, fifo_rd & fifo_empty}, 32'd0);
      if (prev_stall) begin
         check("stall_valid", {31'd0, m_valid}, 32'd1);
         check("stall_data", {24'd0, m_data}, {24'd0, prev_data});
         check("stall_last", {31'd0, m_last}, {31'd0, prev_last});
      end
      if (fifo_rd) begin
         if (first_rd < 0) first_rd = cyc_n;
         last_rd = cyc_n;
         n_rd++;
      end
      if (m_valid) begin
         if (first_val < 0) first_val = cyc_n;
         n_val++;
      end
      if (m_valid && m_ready) begin
         n_acc++;
         last_acc = cyc_n;
         if (exp_d.size() == 0) begin
            check("unexpected_byte", {31'd0, m_valid & m_ready}, 32'd0);
         end else begin
            d = exp_d.pop_front();
            l = exp_l.pop_front();
            $display("byte: cycle %0d data 0x%02h last %0b (expect 0x%02h/%0b)", cyc_n, m_data, m_last, d, l);
            check("data", {24'd0, m_data}, {24'd0, d});
            check("last", {31'd0, m_last}, {31'd0, l});
         end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      cyc_n++;
      @(negedge clk);
   endtask

   // mode 0: hold inputs (flush_req pulses one cycle), 1: m_ready toggles, 2: random inputs
   task automatic drain(input int budget, input int mode);
      bit done = 0;
      for (int k = 0; k < budget && !done; k++) begin
         if (mode == 1) begin
            m_ready = (k % 2 == 0);
         end else if (mode == 2) begin
            m_ready   = ($urandom_range(0, 9) < 6);
            enable    = ($urandom_range(0, 9) != 0);
            flush_req = ($urandom_range(0, 15) == 0);
         end
         cyc();
         if (mode == 0) flush_req = 1'b0;
         done = (exp_d.size() == 0) && !busy && fifo_empty;
      end
      flush_req = 1'b0; enable = 1'b1; m_ready = 1'b1;
      check("drain_done", {31'd0, done}, 32'd1);
      check("burst_count", {16'd0, burst_count}, {16'd0, 16'(exp_bursts)});
      check("byte_count", {16'd0, byte_count}, {16'd0, 16'(exp_bytes)});
   endtask

   initial begin
      int w, b0;
      repeat (3) @(negedge clk);
      check("rst_m_valid", {31'd0, m_valid}, 32'd0);
      check("rst_m_data", {24'd0, m_data}, 32'd0);
      check("rst_m_last", {31'd0, m_last}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_bursts", {16'd0, burst_count}, 32'd0);
      check("rst_bytes", {16'd0, byte_count}, 32'd0);
      check("rst_fifo_rd", {31'd0, fifo_rd}, 32'd0);
      rst_n = 1'b1;
      enable = 1'b1; m_ready = 1'b1;
      repeat (2) cyc();

      // Full burst at 1 byte/cycle
      arm(); w = cyc_n;
      push_batch(8, 8'h10, 0);
      drain(200, 0);
      check("t1_first_rd", first_rd - w, 1);
      check("t1_last_rd", last_rd - w, 8);
      check("t1_first_valid", first_val - w, 2);
      check("t1_last_acc", last_acc - w, 9);
      check("t1_pops", n_rd, 8);
      check("t1_fifo_left", wr_total - rd_total, 0);

      // Timeout flush, 3-cycle cadence
      arm(); w = cyc_n;
      push_batch(3, 8'hA0, 0);
      drain(300, 0);
      check("t2_first_rd", first_rd - w, 32);
      check("t2_first_valid", first_val - w, 34);
      check("t2_last_acc", last_acc - w, 40);
      check("t2_pops", n_rd, 3);

      // Burst then timeout flush under a toggling m_ready
      arm();
      push_batch(12, 8'h30, 0);
      drain(400, 1);
      check("t3_accepts", n_acc, 12);

      // Explicit flush request starts next cycle
      arm(); w = cyc_n;
      push_batch(2, 8'h50, 0);
      flush_req = 1'b1;
      drain(200, 0);
      check("t4_first_rd", first_rd - w, 1);

      // Disabled: no pops, timer held at zero
      enable = 1'b0;
      arm();
      push_batch(2, 8'h60, 0);
      flush_req = 1'b1;
      cyc();
      flush_req = 1'b0;
      repeat (60) cyc();
      check("t4_dis_pops", n_rd, 0);
      check("t4_dis_busy", {31'd0, busy}, 32'd0);
      arm(); w = cyc_n;
      enable = 1'b1;
      drain(300, 0);
      check("t4_timer_from_zero", first_rd - w, 32);

      // Reset mid-burst after three accepted bytes
      arm(); b0 = exp_bytes;
      push_batch(8, 8'h70, 0);
      for (int k = 0; k < 50 && n_acc < 3; k++) cyc();
      check("t5_acc_before_rst", n_acc, 3);
      check("t5_bytes_before_rst", {16'd0, byte_count}, 32'(16'(b0 + 3)));
      rst_n = 1'b0;
      #1;
      check("t5_rst_valid", {31'd0, m_valid}, 32'd0);
      check("t5_rst_busy", {31'd0, busy}, 32'd0);
      check("t5_rst_bursts", {16'd0, burst_count}, 32'd0);
      check("t5_rst_bytes", {16'd0, byte_count}, 32'd0);
      exp_d.delete(); exp_l.delete();
      exp_bytes = 0; exp_bursts = 0; prev_stall = 0;
      @(negedge clk);
      rst_n = 1'b1;
      arm();
      repeat (20) cyc();
      check("t5_post_pops", n_rd, 0);
      check("t5_post_valid", n_val, 0);
      check("t5_fifo_empty", wr_total - rd_total, 0);

      // Empty FIFO, with stray flush requests
      arm();
      for (int k = 0; k < 100; k++) begin
         flush_req = ($urandom_range(0, 9) == 0);
         cyc();
      end
      flush_req = 1'b0;
      check("t6_pops", n_rd, 0);
      check("t6_valid", n_val, 0);

      // Randomized batches with random ready/enable/flush
      for (int s = 0; s < 40; s++) begin
         arm();
         push_batch($urandom_range(1, 16), 8'h00, 1);
         drain(3000, 2);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
Drain-side controller for the 16-entry byte FIFO (fifo_mem read port). Pops bytes in fixed-length bursts when the FIFO reports threshold, or flushes a partial packet after an idle timeout or on explicit request. Emits bytes on a registered valid/ready stream with a last marker. Sits between fifo_mem and the downstream packet consumer.

Parameters:
DATA_W, 8, byte width; must match the FIFO data width.
BURST_LEN, 8, bytes per full burst. Legal range 1..8, no larger than the FIFO threshold level of 8 entries.
TIMEOUT, 32, idle cycles with a non-empty, sub-threshold FIFO before an automatic flush. Legal range 1..65535.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
enable  in  1  permits starting new bursts/flushes
flush_req  in  1  single-cycle pulse; forces a flush from IDLE if FIFO non-empty
fifo_empty  in  1  from FIFO
fifo_threshold  in  1  from FIFO; high when occupancy >= 8
fifo_data  in  DATA_W  FIFO head data; combinational, valid whenever not empty
fifo_rd  out  1  pop strobe to FIFO; combinational
m_valid  out  1  output byte valid; registered
m_ready  in  1  downstream accept
m_data  out  DATA_W  output byte; registered
m_last  out  1  final byte of burst/flush; registered
busy  out  1  high in any state other than IDLE; registered
burst_count  out  16  completed bursts plus flushes; wraps at 65535->0
byte_count  out  16  bytes accepted downstream; wraps

Behaviour:
- Reset: state IDLE, m_valid=0, m_data=0, m_last=0, busy=0, timer=0, pop_cnt=0, burst_count=0, byte_count=0. fifo_rd=0.
- Reset mid-operation: a byte already popped but not yet accepted downstream is discarded.
- fifo_rd is never high while fifo_empty=1.
- Handshake: a byte transfers on a cycle with m_valid & m_ready. While m_valid=1 and m_ready=0, m_data and m_last hold stable.
- Output slot is free when m_valid=0, or when m_valid & m_ready in the same cycle.
- IDLE:
  - enable & fifo_threshold -> BURST, pop_cnt=0. Threshold has priority over a flush.
  - Else enable & !fifo_empty & (flush_req | timer==TIMEOUT-1) -> FLUSH, pop_cnt=0.
  - Else if enable & !fifo_empty, timer++.
  - Else timer=0.
  - timer clears on any exit from IDLE.
- BURST:
  - fifo_rd = slot free & !fifo_empty & pop_cnt<BURST_LEN.
  - On each pop: m_data<=fifo_data, m_valid<=1, m_last<=(pop_cnt==BURST_LEN-1), pop_cnt++.
  - On acceptance of the m_last byte: m_valid<=0, m_last<=0, burst_count++, -> IDLE.
  - Supports 1 byte/cycle when m_ready stays high.
- FLUSH (one byte per 3 cycles minimum):
  - FLUSH: if slot free & !fifo_empty, then fifo_rd=1, capture fifo_data into hold register, -> FLUSH_EVAL.
  - FLUSH_EVAL: m_data<=hold, m_valid<=1, m_last<=fifo_empty | (pop_cnt==BURST_LEN-1), pop_cnt++, -> FLUSH_OUT. fifo_empty here is the post-pop value; a write landing this cycle is not seen.
  - FLUSH_OUT: on acceptance, m_valid<=0. If m_last, then burst_count++ and -> IDLE; else -> FLUSH.
- Latency: fifo_threshold high in IDLE at cycle 0 -> first fifo_rd at cycle 1 -> m_valid at cycle 2.
- enable deasserted mid-burst/flush: the current burst/flush completes untruncated; only new starts are blocked.
- byte_count increments on every accepted byte.
- busy=1 whenever state!=IDLE.

Test Plan:
1. Write 8 bytes 0x10..0x17, m_ready=1 -> fifo_rd high cycles 1..8; m_data 0x10..0x17 on cycles 2..9; m_last only with 0x17; burst_count=1; byte_count=8; FIFO empty.
2. Write 3 bytes 0xA0..0xA2, TIMEOUT=32, no further writes -> flush starts 32 cycles after FIFO goes non-empty; three bytes out in order, m_last only on 0xA2; burst_count=1.
3. Write 12 bytes, m_ready toggling 1/0 each cycle -> first burst delivers 8 bytes with data held stable on stalls, m_last on byte 8; remaining 4 bytes flushed after timeout; byte_count=12; burst_count=2.
4. Write 2 bytes, pulse flush_req -> flush starts the next cycle; with enable=0 the same stimulus produces no fifo_rd, and the timer stays 0.
5. Assert rst_n=0 mid-burst after 3 accepted bytes -> m_valid, busy, and the counters go to 0 immediately; after release the FIFO is empty (FIFO also reset) and the block idles with fifo_rd=0.
6. Empty FIFO with m_ready=1 for 100 cycles -> fifo_rd never asserted; m_valid stays 0.
